// File: rtl/ballot_tally_engine.sv
// ballot_tally_engine: session-based N-candidate vote counter with a sequential winner scan.
// Optional build macro BALLOT_VOTER_LOCKOUT_EN: one accepted vote per voter ID per session.
module ballot_tally_engine #(
    parameter int unsigned NUM_CAND   = 8,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned NUM_VOTERS = 16,
    localparam int unsigned IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1,
    localparam int unsigned VID_W = (NUM_VOTERS > 1) ? $clog2(NUM_VOTERS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             open_i,
    input  logic             close_i,
    input  logic             clear_i,
    input  logic             vote_valid_i,
    input  logic [IDX_W-1:0] vote_cand_i,
    input  logic [VID_W-1:0] voter_id_i,
    output logic             vote_ready_o,
    output logic             vote_ack_o,
    output logic             vote_rej_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] total_o,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic             winner_valid_o,
    output logic [IDX_W-1:0] winner_idx_o,
    output logic [CNT_W-1:0] winner_cnt_o,
    output logic             tie_o,
    output logic             no_votes_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OPEN  = 2'd1,
        S_TALLY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt_q [NUM_CAND];
    logic [CNT_W-1:0] total_q;
    logic             ack_q;
    logic             rej_q;
    logic [CNT_W-1:0] rd_cnt_q;

    // Scan bookkeeping
    logic [IDX_W-1:0] scan_idx;
    logic [CNT_W-1:0] run_max;
    logic [IDX_W-1:0] run_idx;
    logic             run_tie;

    // Result registers
    logic             res_valid;
    logic [IDX_W-1:0] res_idx;
    logic [CNT_W-1:0] res_cnt;
    logic             res_tie;
    logic             res_none;

    // Combinational helpers
    logic             vote_take;
    logic             cand_ok;
    logic [CNT_W-1:0] cand_cnt;
    logic             voter_ok;
    logic             vote_ok;
    logic             vote_inc;
    logic             clr_session;
    logic [CNT_W-1:0] scan_cnt;
    logic             scan_last;
    logic [CNT_W-1:0] nxt_max;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_tie;
    logic             nxt_none;
    logic             rd_ok;

`ifdef BALLOT_VOTER_LOCKOUT_EN
    logic [NUM_VOTERS-1:0] voted_q;
    logic                  vid_ok;

    // Voter must be in range and must not have voted yet this session
    always_comb begin
        vid_ok   = 32'(voter_id_i) < NUM_VOTERS;
        voter_ok = 1'b0;
        if (vid_ok) begin
            voter_ok = ~voted_q[voter_id_i];
        end
    end

    // Has-voted bitmap, cleared at every session boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            voted_q <= '0;
        end else if (clr_session) begin
            voted_q <= '0;
        end else if (vote_inc) begin
            for (int i = 0; i < int'(NUM_VOTERS); i++) begin
                if (voter_id_i == VID_W'(i)) begin
                    voted_q[i] <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_voter_id;

    // Voter identity plays no part in acceptance in this build
    always_comb begin
        unused_voter_id = ^voter_id_i;
        voter_ok        = 1'b1;
    end
`endif

    // Vote acceptance decision for the cycle a request is taken
    always_comb begin
        vote_take = (state == S_OPEN) && vote_valid_i && !clear_i;
        cand_ok   = 32'(vote_cand_i) < NUM_CAND;
        cand_cnt  = '0;
        if (cand_ok) begin
            cand_cnt = cnt_q[vote_cand_i];
        end
        vote_ok  = cand_ok && (cand_cnt != CNT_MAX) && (total_q != CNT_MAX) && voter_ok;
        vote_inc = vote_take && vote_ok;
        clr_session = clear_i || (open_i && ((state == S_IDLE) || (state == S_DONE)));
    end

    // One step of the winner scan: lowest index wins, equality marks a tie
    always_comb begin
        scan_cnt  = cnt_q[scan_idx];
        scan_last = 32'(scan_idx) == (NUM_CAND - 1);
        nxt_max   = run_max;
        nxt_idx   = run_idx;
        nxt_tie   = run_tie;
        if (scan_idx == '0) begin
            nxt_max = scan_cnt;
            nxt_idx = '0;
            nxt_tie = 1'b0;
        end else if (scan_cnt > run_max) begin
            nxt_max = scan_cnt;
            nxt_idx = scan_idx;
            nxt_tie = 1'b0;
        end else if (scan_cnt == run_max) begin
            nxt_tie = 1'b1;
        end
        nxt_none = (nxt_max == '0);
    end

    // Per-candidate counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CAND); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (clr_session) begin
            for (int i = 0; i < int'(NUM_CAND); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (vote_inc) begin
            for (int i = 0; i < int'(NUM_CAND); i++) begin
                if (vote_cand_i == IDX_W'(i)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Session FSM with handshake pulses, total, scan and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            total_q   <= '0;
            ack_q     <= 1'b0;
            rej_q     <= 1'b0;
            scan_idx  <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            run_tie   <= 1'b0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_cnt   <= '0;
            res_tie   <= 1'b0;
            res_none  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            rej_q <= 1'b0;
            if (clear_i) begin
                state     <= S_IDLE;
                total_q   <= '0;
                scan_idx  <= '0;
                run_max   <= '0;
                run_idx   <= '0;
                run_tie   <= 1'b0;
                res_valid <= 1'b0;
                res_idx   <= '0;
                res_cnt   <= '0;
                res_tie   <= 1'b0;
                res_none  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (open_i) begin
                            state     <= S_OPEN;
                            total_q   <= '0;
                            res_valid <= 1'b0;
                            res_idx   <= '0;
                            res_cnt   <= '0;
                            res_tie   <= 1'b0;
                            res_none  <= 1'b0;
                        end
                    end
                    S_OPEN: begin
                        if (vote_take) begin
                            ack_q <= vote_ok;
                            rej_q <= ~vote_ok;
                        end
                        if (vote_inc) begin
                            total_q <= total_q + CNT_W'(1);
                        end
                        if (close_i) begin
                            state    <= S_TALLY;
                            scan_idx <= '0;
                        end
                    end
                    S_TALLY: begin
                        run_max <= nxt_max;
                        run_idx <= nxt_idx;
                        run_tie <= nxt_tie;
                        if (scan_last) begin
                            state     <= S_DONE;
                            scan_idx  <= '0;
                            res_none  <= nxt_none;
                            res_tie   <= nxt_tie && !nxt_none;
                            res_valid <= !nxt_tie && !nxt_none;
                            res_idx   <= nxt_idx;
                            res_cnt   <= nxt_max;
                        end else begin
                            scan_idx <= scan_idx + IDX_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Registered count readback, zero for out-of-range selects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_ok ? cnt_q[rd_idx_i] : '0;
        end
    end

    // Readback select range check
    always_comb begin
        rd_ok = 32'(rd_idx_i) < NUM_CAND;
    end

    assign vote_ready_o   = (state == S_OPEN);
    assign vote_ack_o     = ack_q;
    assign vote_rej_o     = rej_q;
    assign state_o        = state;
    assign total_o        = total_q;
    assign rd_cnt_o       = rd_cnt_q;
    assign winner_valid_o = res_valid;
    assign winner_idx_o   = res_idx;
    assign winner_cnt_o   = res_cnt;
    assign tie_o          = res_tie;
    assign no_votes_o     = res_none;

endmodule

// File: tb/tb_ballot_tally_engine.sv
// Scoreboard bench for ballot_tally_engine with a session-level reference model.
module tb_ballot_tally_engine;

    localparam int unsigned NC   = 6;
    localparam int unsigned CW   = 4;
    localparam int unsigned NV   = 12;
    localparam int unsigned IW   = 3;
    localparam int unsigned VW   = 4;
    localparam int          MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          open_i, close_i, clear_i, vote_valid_i;
    logic [IW-1:0] vote_cand_i, rd_idx_i, winner_idx_o;
    logic [VW-1:0] voter_id_i;
    logic          vote_ready_o, vote_ack_o, vote_rej_o;
    logic [1:0]    state_o;
    logic [CW-1:0] total_o, rd_cnt_o, winner_cnt_o;
    logic          winner_valid_o, tie_o, no_votes_o;

    ballot_tally_engine #(.NUM_CAND(NC), .CNT_W(CW), .NUM_VOTERS(NV)) dut (
        .clk(clk), .rst(rst), .open_i(open_i), .close_i(close_i), .clear_i(clear_i),
        .vote_valid_i(vote_valid_i), .vote_cand_i(vote_cand_i), .voter_id_i(voter_id_i),
        .vote_ready_o(vote_ready_o), .vote_ack_o(vote_ack_o), .vote_rej_o(vote_rej_o),
        .state_o(state_o), .total_o(total_o), .rd_idx_i(rd_idx_i), .rd_cnt_o(rd_cnt_o),
        .winner_valid_o(winner_valid_o), .winner_idx_o(winner_idx_o),
        .winner_cnt_o(winner_cnt_o), .tie_o(tie_o), .no_votes_o(no_votes_o)
    );

    always #5 clk = ~clk;

    typedef struct { bit ack; int total; } exp_t;
    exp_t exp_q[$];

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference model: session state (0..3), tallies and voter bitmap
    int m_state;
    int m_cnt[NC];
    int m_total;
    bit m_voted[NV];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < int'(NC); i++) m_cnt[i] = 0;
        for (int i = 0; i < int'(NV); i++) m_voted[i] = 1'b0;
        m_total = 0;
    endfunction

    function automatic bit model_vote(input int c, input int v);
        bit ok;
        ok = 1'b1;
        if (c >= int'(NC)) ok = 1'b0;
        else if (m_cnt[c] == MAXC) ok = 1'b0;
        if (m_total == MAXC) ok = 1'b0;
`ifdef BALLOT_VOTER_LOCKOUT_EN
        if (v >= int'(NV)) ok = 1'b0;
        else if (m_voted[v]) ok = 1'b0;
`endif
        if (ok) begin
            m_cnt[c]++;
            m_total++;
`ifdef BALLOT_VOTER_LOCKOUT_EN
            m_voted[v] = 1'b1;
`endif
        end
        return ok;
    endfunction

    // Monitor: every ack/rej pulse is matched against the oldest expected vote
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (vote_ack_o && vote_rej_o) begin
                    chk("ack_rej_exclusive", 1, 0);
                end else if (vote_ack_o || vote_rej_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("vote_ack", int'(vote_ack_o), int'(e.ack));
                        chk("total_after_vote", int'(total_o), e.total);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && exp_q.size() > 0; i++) tick();
        chk("pending_votes", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic push_vote(input int c, input int v);
        exp_t e;
        if (m_state == 1) begin
            e.ack   = model_vote(c, v);
            e.total = m_total;
            exp_q.push_back(e);
        end
    endtask

    task automatic vote(input int c, input int v);
        vote_valid_i = 1'b1;
        vote_cand_i  = IW'(c);
        voter_id_i   = VW'(v);
        push_vote(c, v);
        tick();
        vote_valid_i = 1'b0;
    endtask

    task automatic do_open();
        open_i = 1'b1;
        tick();
        open_i = 1'b0;
        if (m_state == 0 || m_state == 3) begin
            model_clear();
            m_state = 1;
        end
        chk("state_open", int'(state_o), 1);
        chk("ready_open", int'(vote_ready_o), 1);
    endtask

    task automatic check_results(input string tag);
        int mx, n, idx, nv, tie;
        mx = 0; n = 0; idx = 0;
        foreach (m_cnt[i]) if (m_cnt[i] > mx) mx = m_cnt[i];
        foreach (m_cnt[i]) if (m_cnt[i] == mx) begin
            if (n == 0) idx = i;
            n++;
        end
        nv  = (mx == 0) ? 1 : 0;
        tie = (n > 1 && nv == 0) ? 1 : 0;
        chk({tag, "_no_votes"}, int'(no_votes_o), nv);
        chk({tag, "_tie"}, int'(tie_o), tie);
        chk({tag, "_winner_valid"}, int'(winner_valid_o), (tie == 0 && nv == 0) ? 1 : 0);
        chk({tag, "_winner_idx"}, int'(winner_idx_o), idx);
        chk({tag, "_winner_cnt"}, int'(winner_cnt_o), mx);
        chk({tag, "_total"}, int'(total_o), m_total);
        chk({tag, "_ready_done"}, int'(vote_ready_o), 0);
        for (int i = 0; i < 8; i++) begin
            rd_idx_i = IW'(i);
            tick();
            chk({tag, "_rd_cnt"}, int'(rd_cnt_o), (i < int'(NC)) ? m_cnt[i] : 0);
        end
    endtask

    // Close the session (optionally with a same-cycle vote) and walk the scan
    task automatic do_close(input string tag, input bit with_vote, input int c, input int v);
        close_i = 1'b1;
        if (with_vote) begin
            vote_valid_i = 1'b1;
            vote_cand_i  = IW'(c);
            voter_id_i   = VW'(v);
            push_vote(c, v);
        end
        tick();
        close_i      = 1'b0;
        vote_valid_i = 1'b0;
        m_state      = 2;
        chk({tag, "_state_tally"}, int'(state_o), 2);
        chk({tag, "_ready_tally"}, int'(vote_ready_o), 0);
        repeat (NC - 1) tick();
        chk({tag, "_state_last_tally"}, int'(state_o), 2);
        tick();
        m_state = 3;
        chk({tag, "_state_done"}, int'(state_o), 3);
        drain();
        check_results(tag);
    endtask

    initial begin
        rst = 1'b1;
        open_i = 0; close_i = 0; clear_i = 0; vote_valid_i = 0;
        vote_cand_i = '0; voter_id_i = '0; rd_idx_i = '0;
        m_state = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_outputs", int'({vote_ready_o, vote_ack_o, vote_rej_o, winner_valid_o, tie_o, no_votes_o}), 0);
        chk("rst_counts", int'(total_o) + int'(rd_cnt_o) + int'(winner_cnt_o) + int'(winner_idx_o), 0);
        rst = 1'b0;
        tick();

        // Votes in IDLE are neither counted nor answered
        vote(1, 0);
        tick();
        chk("idle_total", int'(total_o), 0);
        chk("idle_ready", int'(vote_ready_o), 0);

        // Unique winner
        do_open();
        vote(2, 1); vote(2, 2); vote(2, 3); vote(0, 4);
        drain();
        do_close("unique", 1'b0, 0, 0);

        // close_i and votes ignored in DONE
        close_i = 1'b1;
        tick();
        close_i = 1'b0;
        chk("done_close_ignored", int'(state_o), 3);
        vote(1, 5);
        tick();
        chk("done_vote_ignored", int'(total_o), m_total);

        // Tie, plus an out-of-range candidate and an ignored open_i
        do_open();
        vote(1, 5); vote(3, 6); vote(1, 7); vote(3, 8); vote(7, 9);
        drain();
        open_i = 1'b1;
        tick();
        open_i = 1'b0;
        chk("open_in_open_ignored", int'(total_o), m_total);
        do_close("tie", 1'b0, 0, 0);

        // No votes
        do_open();
        do_close("none", 1'b0, 0, 0);

        // Saturation: 16 votes to one candidate
        do_open();
        for (int j = 0; j < 16; j++) vote(0, j);
        drain();
        do_close("sat", 1'b0, 0, 0);

        // Vote taken together with close_i
        do_open();
        vote(4, 1);
        do_close("closevote", 1'b1, 4, 2);

        // Repeat voter, then a fresh session, then an out-of-range voter
        do_open();
        vote(1, 3); vote(1, 3);
        do_close("lock_a", 1'b0, 0, 0);
        do_open();
        vote(1, 3); vote(2, 13);
        do_close("lock_b", 1'b0, 0, 0);

        // clear_i in the middle of TALLY
        do_open();
        vote(5, 0); vote(5, 1);
        drain();
        close_i = 1'b1;
        tick();
        close_i = 1'b0;
        tick(); tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        m_state = 0;
        model_clear();
        chk("clear_state", int'(state_o), 0);
        chk("clear_results", int'({winner_valid_o, tie_o, no_votes_o}), 0);
        chk("clear_winner", int'(winner_cnt_o) + int'(winner_idx_o), 0);
        chk("clear_total", int'(total_o), 0);
        rd_idx_i = IW'(5);
        tick();
        chk("clear_rd_cnt", int'(rd_cnt_o), 0);

        // clear_i alongside a vote in OPEN: no pulse, nothing counted
        do_open();
        vote_valid_i = 1'b1;
        vote_cand_i  = IW'(2);
        voter_id_i   = VW'(0);
        clear_i      = 1'b1;
        tick();
        vote_valid_i = 1'b0;
        clear_i      = 1'b0;
        m_state      = 0;
        model_clear();
        tick();
        chk("clear_vote_state", int'(state_o), 0);
        chk("clear_vote_total", int'(total_o), 0);

        // Asynchronous reset while OPEN
        do_open();
        vote(2, 0); vote(2, 1);
        drain();
        rd_idx_i = IW'(2);
        tick();
        chk("pre_rst_rd_cnt", int'(rd_cnt_o), m_cnt[2]);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", int'(state_o), 0);
        chk("arst_flags", int'({vote_ready_o, vote_ack_o, vote_rej_o, winner_valid_o, tie_o, no_votes_o}), 0);
        chk("arst_total", int'(total_o), 0);
        chk("arst_rd_cnt", int'(rd_cnt_o), 0);
        tick();
        rst = 1'b0;
        m_state = 0;
        model_clear();
        tick();

        // Randomized sessions
        for (int s = 0; s < 8; s++) begin
            int k;
            do_open();
            k = $urandom_range(0, 20);
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 3) == 0) tick();
                vote($urandom_range(0, 7), $urandom_range(0, 15));
            end
            do_close("rand", ($urandom_range(0, 1) == 1), $urandom_range(0, 7), $urandom_range(0, 15));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
